serial_mult_ctrl: RTL

Sequencer for the bit-serial 16x16 unsigned shift-add multiplier datapath (serial_mult_core). It accepts parallel operand pairs over a valid/ready handshake and holds the multiplicand on the core. It feeds multiplier bits LSB-first, then zero-flushes the carry-save state, and collects the serial product bits into a parallel 2W-bit result. The result is presented on a second valid/ready handshake. It sits between the operand producer and result consumer; the core is instantiated beside it in the wrapper.

---
 rtl/serial_mult_ctrl_pkg.sv | 14 +
 rtl/serial_mult_ctrl_if.sv | 26 ++
 rtl/serial_mult_ctrl_core.sv | 40 ++++
 rtl/serial_mult_ctrl.sv | 100 ++++++++++
 4 files changed

// File: rtl/serial_mult_ctrl_pkg.sv
// Shared constants and state encoding for the serial multiplier sequencer.
package mult_ctrl_pkg;

  localparam int unsigned W_DEFAULT = 16;
  localparam int unsigned CNT_W     = $clog2(2 * W_DEFAULT);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/serial_mult_ctrl_if.sv
// Operand and result valid/ready handshakes between producer/consumer and controller.
interface serial_mult_ctrl_if
  import mult_ctrl_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
);

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_product;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_product
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_product
  );

endinterface

// File: rtl/serial_mult_ctrl_core.sv
// Bit-serial carry-save shift-add multiplier datapath: one multiplier bit per
// enabled step, one product bit out per step (LSB first, combinational).
module serial_mult_core #(
  parameter int unsigned W = mult_ctrl_pkg::W_DEFAULT
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] mcand,
  input  logic         mbit,
  output logic         pout
);

  logic [W-1:0] s_reg;
  logic [W-1:0] c_reg;
  logic [W-1:0] pp;
  logic [W-1:0] fa_s;
  logic [W-1:0] fa_c;

  // Row of full adders: partial product + saved sum + saved carry per column.
  always_comb begin
    pp   = mcand & {W{mbit}};
    fa_s = pp ^ s_reg ^ c_reg;
    fa_c = (pp & s_reg) | (pp & c_reg) | (s_reg & c_reg);
    pout = fa_s[0];
  end

  // Retire bit 0 each step: sums shift down one column, carries drop into
  // the column they already belong to after the shift.
  always_ff @(posedge clk) begin
    if (clear) begin
      s_reg <= '0;
      c_reg <= '0;
    end else if (en) begin
      s_reg <= {1'b0, fa_s[W-1:1]};
      c_reg <= fa_c;
    end
  end

endmodule

// File: rtl/serial_mult_ctrl.sv
// Sequencer for serial_mult_core: accepts an operand pair, clears the core,
// streams 2W bit-steps (multiplier bits then zero flush), collects the
// serial product and presents it on the output handshake.
module serial_mult_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  serial_mult_ctrl_if.slave   bus,
  output logic                busy,
  output logic                core_clear,
  output logic                core_en,
  output logic [W-1:0]        core_mcand,
  output logic                core_bit,
  input  logic                core_pout
);

  localparam int unsigned CW = $clog2(2 * W);

  state_t         state;
  state_t         state_nx;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_sh;
  logic [2*W-1:0] prod_sh;
  logic           last_step;

  assign last_step = (cnt == CW'(2 * W - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake/core control decode.
  always_comb begin
    state_nx        = state;
    bus.in_ready    = 1'b0;
    bus.out_valid   = 1'b0;
    bus.out_product = '0;
    busy            = 1'b1;
    core_clear      = 1'b0;
    core_en         = 1'b0;
    core_bit        = 1'b0;
    core_mcand      = a_reg;
    case (state)
      IDLE: begin
        busy         = 1'b0;
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = CLEAR;
      end
      CLEAR: begin
        core_clear = 1'b1;
        state_nx   = RUN;
      end
      RUN: begin
        core_en  = 1'b1;
        core_bit = (cnt < CW'(W)) ? b_sh[0] : 1'b0;
        if (last_step) state_nx = DONE;
      end
      DONE: begin
        bus.out_valid   = 1'b1;
        bus.out_product = prod_sh;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, step counter and product collection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      a_reg   <= '0;
      b_sh    <= '0;
      prod_sh <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.in_a;
            b_sh  <= bus.in_b;
          end
        end
        CLEAR: cnt <= '0;
        RUN: begin
          // Counter parks at its final value instead of wrapping.
          if (!last_step) cnt <= cnt + 1'b1;
          b_sh    <= b_sh >> 1;
          prod_sh <= {core_pout, prod_sh[2*W-1:1]};
        end
        default: ;
      endcase
    end
  end

endmodule
